// File: rtl/ext_memory_if.sv
// Request/response bus between a core and the external memory model.
// The core drives the request side; the memory answers with a ready pulse and read data.
interface ext_memory_if;
   logic        ext_valid;
   logic        ext_instruction;
   logic        ext_ready;
   logic [31:0] ext_address;
   logic [31:0] ext_write_data;
   logic [3:0]  ext_write_strobe;
   logic [31:0] ext_read_data;

   modport master (
      output ext_valid, ext_instruction, ext_address, ext_write_data, ext_write_strobe,
      input  ext_ready, ext_read_data
   );

   modport slave (
      input  ext_valid, ext_instruction, ext_address, ext_write_data, ext_write_strobe,
      output ext_ready, ext_read_data
   );
endinterface

// File: rtl/ext_memory.sv
// Word-organised external memory with fixed access latency and a memory-mapped halt register.
// A request is captured in IDLE, timed by a down-counter, and completed by a one-cycle ready pulse.
//
//   state | meaning
//   IDLE  | waiting for ext_valid; captures the request
//   WAIT  | latency down-counter running; bus inputs ignored
//   ACK   | ext_ready high for one cycle; write/halt committed on exit
module ext_memory #(
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] HALT_ADDR   = 32'hFFFF_FFF0
) (
   input  logic         clk,
   input  logic         reset,
   ext_memory_if.slave  bus,
   output logic         halt,
   output logic [31:0]  halt_code
);

   localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [29:0] cap_word;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_strb;
   logic        cap_instr;
   logic [31:0] rd_hold;
   logic [31:0] rd_word;

   logic [31:0] mem [DEPTH_WORDS];

   logic          in_range;
   logic          hit_halt;
   logic          is_write;
   logic [AW-1:0] idx;
   logic          unused_addr_lsbs;

   assign unused_addr_lsbs = ^bus.ext_address[1:0];

   assign in_range = {2'b00, cap_word} < 32'(DEPTH_WORDS);
   assign hit_halt = cap_word == HALT_ADDR[31:2];
   // A fetch never writes, even when it carries a stray strobe.
   assign is_write = (cap_strb != 4'b0000) && !cap_instr;
   assign idx      = cap_word[AW-1:0];

   always_comb begin
      rd_word = '0;
      if (hit_halt)
         rd_word = halt_code;
      else if (in_range)
         rd_word = mem[idx];
   end

   assign bus.ext_ready     = (state == ACK) && !reset;
   assign bus.ext_read_data = (state == ACK) ? rd_word : rd_hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_word  <= '0;
         cap_wdata <= '0;
         cap_strb  <= '0;
         cap_instr <= 1'b0;
         rd_hold   <= '0;
         halt      <= 1'b0;
         halt_code <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.ext_valid) begin
                  cap_word  <= bus.ext_address[31:2];
                  cap_wdata <= bus.ext_write_data;
                  cap_strb  <= bus.ext_write_strobe;
                  cap_instr <= bus.ext_instruction;
                  cnt       <= CNT_LOAD;
                  state     <= (LATENCY == 1) ? ACK : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               // terminal count: the decrement lands on zero this edge
               if (cnt <= 4'd1)
                  state <= ACK;
            end
            ACK: begin
               state   <= IDLE;
               rd_hold <= rd_word;
               if (is_write && hit_halt) begin
                  halt      <= 1'b1;
                  halt_code <= cap_wdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM has no reset so its contents survive a core reset.
   always_ff @(posedge clk) begin
      if (!reset && (state == ACK) && is_write && in_range && !hit_halt) begin
         for (int b = 0; b < 4; b++) begin
            if (cap_strb[b])
               mem[idx][8*b +: 8] <= cap_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ext_memory.sv
// Self-checking bench for ext_memory: directed scenarios plus randomized accesses
// compared against a word-array reference model with byte-lane merge and halt register.
module tb_ext_memory;

   localparam int          DEPTH = 4096;
   localparam int          LAT   = 2;
   localparam logic [31:0] HALT  = 32'hFFFF_FFF0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset1 = 1'b1;
   always #5 clk = ~clk;

   ext_memory_if bus0();
   ext_memory_if bus1();

   logic        halt0, halt1;
   logic [31:0] code0, code1;

   ext_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .HALT_ADDR(HALT)) u_mem (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus0),
      .halt      (halt0),
      .halt_code (code0)
   );

   ext_memory #(.DEPTH_WORDS(256), .LATENCY(1), .HALT_ADDR(HALT)) u_mem_l1 (
      .clk       (clk),
      .reset     (reset1),
      .bus       (bus1),
      .halt      (halt1),
      .halt_code (code1)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] ref_mem [DEPTH];
   bit          known   [DEPTH];
   bit          m_halt = 1'b0;
   logic [31:0] m_code = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete access on the LATENCY=2 instance; starts and ends on a negedge.
   task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic instr);
      logic [31:0] word;
      logic [31:0] exp;
      bit          is_wr, in_rng, do_chk, seen;
      int          n;
      word   = {2'b00, addr[31:2]};
      is_wr  = (strb != 4'b0000) && !instr;
      in_rng = word < DEPTH;
      do_chk = 1'b0;
      exp    = '0;
      if (!is_wr) begin
         if (word == {2'b00, HALT[31:2]}) begin exp = m_code; do_chk = 1'b1; end
         else if (!in_rng)                begin exp = '0;     do_chk = 1'b1; end
         else if (known[word[11:0]])      begin exp = ref_mem[word[11:0]]; do_chk = 1'b1; end
      end

      reset                 = 1'b0;
      bus0.ext_valid        = 1'b1;
      bus0.ext_address      = addr;
      bus0.ext_write_data   = wdata;
      bus0.ext_write_strobe = strb;
      bus0.ext_instruction  = instr;

      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (bus0.ext_ready) seen = 1'b1;
         else begin
            // junk on the bus while the access is in flight must be ignored
            bus0.ext_address      = $urandom;
            bus0.ext_write_data   = $urandom;
            bus0.ext_write_strobe = 4'($urandom);
            bus0.ext_instruction  = 1'($urandom);
         end
      end
      check("latency", 32'(n), 32'(LAT));
      if (do_chk) check("rdata", bus0.ext_read_data, exp);
      bus0.ext_valid = 1'b0;

      if (is_wr) begin
         if (word == {2'b00, HALT[31:2]}) begin
            m_halt = 1'b1;
            m_code = wdata;
         end else if (in_rng) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) ref_mem[word[11:0]][8*b +: 8] = wdata[8*b +: 8];
            if (strb == 4'hF) known[word[11:0]] = 1'b1;
         end
      end

      @(negedge clk);
      check("ready_one_cycle", 32'(bus0.ext_ready), 32'd0);
      check("halt", 32'(halt0), 32'(m_halt));
      check("halt_code", code0, m_code);
      if (do_chk) check("rdata_hold", bus0.ext_read_data, exp);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [3:0]  s;
      logic        f;
      int          r;

      bus0.ext_valid = 1'b0; bus0.ext_address = '0; bus0.ext_write_data = '0;
      bus0.ext_write_strobe = '0; bus0.ext_instruction = 1'b0;
      bus1.ext_valid = 1'b0; bus1.ext_address = '0; bus1.ext_write_data = '0;
      bus1.ext_write_strobe = '0; bus1.ext_instruction = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus0.ext_ready), 32'd0);
      check("rst_rdata", bus0.ext_read_data, 32'd0);
      check("rst_halt", 32'(halt0), 32'd0);
      check("rst_halt_code", code0, 32'd0);

      // write then fetch, first request lands on the cycle reset drops
      access(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0);
      access(32'h0000_0100, 32'h0, 4'h0, 1'b1);
      access(32'h0000_0100, 32'h0BAD_0BAD, 4'hF, 1'b1);
      access(32'h0000_0101, 32'h0, 4'h0, 1'b0);

      // partial-strobe merge
      access(32'h0000_0104, 32'h1122_3344, 4'hF, 1'b0);
      access(32'h0000_0104, 32'hAABB_CCDD, 4'b0101, 1'b0);
      access(32'h0000_0104, 32'h0, 4'h0, 1'b0);

      // out of range: reads zero, write discarded (would alias word 0)
      access(32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1'b0);
      access(32'h0001_0000, 32'h0000_0BAD, 4'hF, 1'b0);
      access(32'h0001_0000, 32'h0, 4'h0, 1'b0);
      access(32'h0000_0000, 32'h0, 4'h0, 1'b0);

      // halt register
      access(HALT, 32'h0000_0001, 4'b0001, 1'b0);
      access(HALT, 32'h0, 4'h0, 1'b0);
      access(32'h0000_0100, 32'h0, 4'h0, 1'b0);
      access(HALT, 32'h1234_5678, 4'hF, 1'b1);
      access(HALT | 32'h3, 32'h0, 4'h0, 1'b0);

      // reset in WAIT aborts the write
      access(32'h0000_0200, 32'h5555_AAAA, 4'hF, 1'b0);
      bus0.ext_valid = 1'b1; bus0.ext_address = 32'h0000_0200;
      bus0.ext_write_data = 32'h1234_5678; bus0.ext_write_strobe = 4'hF;
      bus0.ext_instruction = 1'b0;
      @(negedge clk);
      check("wait_no_ready", 32'(bus0.ext_ready), 32'd0);
      reset = 1'b1;
      bus0.ext_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_ready", 32'(bus0.ext_ready), 32'd0);
      end
      check("abort_halt_cleared", 32'(halt0), 32'd0);
      check("abort_code_cleared", code0, 32'd0);
      check("abort_rdata_cleared", bus0.ext_read_data, 32'd0);
      m_halt = 1'b0;
      m_code = '0;
      access(32'h0000_0200, 32'h0, 4'h0, 1'b1);

      // randomized traffic over a small word pool plus out-of-range and halt addresses
      for (int w = 0; w < 16; w++)
         access(32'h0000_0100 + 32'(w * 4), $urandom, 4'hF, 1'b0);
      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 9);
         if (r <= 5)      a = 32'h0000_0100 + 32'($urandom_range(0, 15) * 4);
         else if (r <= 7) a = 32'h0000_4000 | ($urandom & 32'h0FFF_FFFC);
         else             a = HALT;
         a[1:0] = 2'($urandom);
         d = $urandom;
         s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         f = ($urandom_range(0, 3) == 0);
         if (r == 9 && $urandom_range(0, 2) != 0) s = 4'h0;
         access(a, d, s, f);
      end

      // LATENCY=1 instance with valid held high: ready every second cycle
      reset1 = 1'b0;
      bus1.ext_valid = 1'b1;
      bus1.ext_address = 32'h0001_0000;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("l1_ready", 32'(bus1.ext_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 0) check("l1_rdata", bus1.ext_read_data, 32'd0);
      end
      bus1.ext_valid = 1'b0;
      check("l1_halt", 32'(halt1), 32'd0);
      check("l1_halt_code", code1, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
